// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a two-output gate DUT, waits a settle interval, then compares
// both outputs against parameterized truth tables and reports error count and first failure.
module truth_table_checker #(
  parameter int unsigned            N_IN   = 2,
  parameter logic [2**N_IN-1:0]     EXP_A  = 4'b0010,
  parameter logic [2**N_IN-1:0]     EXP_B  = 4'b0111,
  parameter int unsigned            SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_a,
  input  logic            dut_b,
  output logic [N_IN-1:0] x_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [1:0]      first_fail_mask
);

  localparam int unsigned     CntW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [N_IN-1:0] LastVec  = {N_IN{1'b1}};
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE);

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [N_IN-1:0] r_x_vec, w_x_vec_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  logic            r_pass, w_pass_d;
  logic [N_IN:0]   r_err_cnt, w_err_cnt_d;
  logic            r_ff_valid, w_ff_valid_d;
  logic [N_IN-1:0] r_ff_vec, w_ff_vec_d;
  logic [1:0]      r_ff_mask, w_ff_mask_d;

  logic w_ma, w_mb, w_start_ok, w_last;

  assign w_ma       = dut_a ^ EXP_A[r_x_vec];
  assign w_mb       = dut_b ^ EXP_B[r_x_vec];
  assign w_start_ok = start && (r_state == StIdle || r_state == StDone);
  assign w_last     = (r_x_vec == LastVec);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) w_state_d = (SETTLE == 0) ? StCheck : StWait;
      end
      StWait: begin
        if (r_cnt == CntW'(1)) w_state_d = StCheck;
      end
      StCheck: begin
        if (w_last) w_state_d = StDone;
        else        w_state_d = (SETTLE == 0) ? StCheck : StWait;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d      = r_cnt;
    w_x_vec_d    = r_x_vec;
    w_busy_d     = r_busy;
    w_done_d     = r_done;
    w_pass_d     = r_pass;
    w_err_cnt_d  = r_err_cnt;
    w_ff_valid_d = r_ff_valid;
    w_ff_vec_d   = r_ff_vec;
    w_ff_mask_d  = r_ff_mask;
    if (w_start_ok) begin
      w_cnt_d      = SettleLd;
      w_x_vec_d    = '0;
      w_busy_d     = 1'b1;
      w_done_d     = 1'b0;
      w_pass_d     = 1'b0;
      w_err_cnt_d  = '0;
      w_ff_valid_d = 1'b0;
      w_ff_vec_d   = '0;
      w_ff_mask_d  = '0;
    end else if (r_state == StWait) begin
      w_cnt_d = r_cnt - CntW'(1);
    end else if (r_state == StCheck) begin
      if (w_ma || w_mb) begin
        w_err_cnt_d = r_err_cnt + (N_IN + 1)'(1);
        // Only the first failing vector is recorded.
        if (!r_ff_valid) begin
          w_ff_valid_d = 1'b1;
          w_ff_vec_d   = r_x_vec;
          w_ff_mask_d  = {w_ma, w_mb};
        end
      end
      if (w_last) begin
        w_busy_d = 1'b0;
        w_done_d = 1'b1;
        w_pass_d = (w_err_cnt_d == '0);
      end else begin
        w_x_vec_d = r_x_vec + N_IN'(1);
        w_cnt_d   = SettleLd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_x_vec    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
      r_ff_mask  <= '0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_x_vec    <= w_x_vec_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_pass     <= w_pass_d;
      r_err_cnt  <= w_err_cnt_d;
      r_ff_valid <= w_ff_valid_d;
      r_ff_vec   <= w_ff_vec_d;
      r_ff_mask  <= w_ff_mask_d;
    end
  end

  assign x_vec            = r_x_vec;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_cnt          = r_err_cnt;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_mask  = r_ff_mask;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checker instances (SETTLE=1 and SETTLE=0) driving behavioural gate
// models whose truth tables are set per test, covering fixed vectors, corner sequences and random tables.
module tb_truth_table_checker;

  localparam logic [3:0] ExpA = 4'b0010;
  localparam logic [3:0] ExpB = 4'b0111;

  logic       clk;
  logic       rst_s   [2];
  logic       start_s [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic [1:0] xv      [2];
  logic       busy    [2];
  logic       done    [2];
  logic       pass    [2];
  logic [2:0] err     [2];
  logic       ffv     [2];
  logic [1:0] ffvec   [2];
  logic [1:0] mask    [2];
  logic [3:0] ta      [2];
  logic [3:0] tb_t    [2];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: output = truth table indexed by the applied vector.
  assign a_s[0] = ta[0][xv[0]];
  assign b_s[0] = tb_t[0][xv[0]];
  assign a_s[1] = ta[1][xv[1]];
  assign b_s[1] = tb_t[1][xv[1]];

  truth_table_checker #(.N_IN(2), .EXP_A(4'b0010), .EXP_B(4'b0111), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .dut_a(a_s[0]), .dut_b(b_s[0]),
    .x_vec(xv[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0]),
    .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0]), .first_fail_mask(mask[0])
  );

  truth_table_checker #(.N_IN(2), .EXP_A(4'b0010), .EXP_B(4'b0111), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .dut_a(a_s[1]), .dut_b(b_s[1]),
    .x_vec(xv[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err[1]),
    .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1]), .first_fail_mask(mask[1])
  );

  typedef struct {
    int         sel;
    logic [3:0] fa;
    logic [3:0] fb;
    int         err;
    int         ffv;
    int         fvec;
    int         fmask;
    int         restart;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input int s, input string name);
    check(name, int'({xv[s], busy[s], done[s], pass[s], err[s], ffv[s], ffvec[s], mask[s]}), 0);
  endtask

  // Reference: mismatch set is the OR of table differences; first fail is its lowest set bit.
  function automatic void model(input logic [3:0] fa, input logic [3:0] fb, output int e,
                                output int f_valid, output int f_vec, output int f_mask);
    logic [3:0] da;
    logic [3:0] db;
    da = fa ^ ExpA;
    db = fb ^ ExpB;
    e = 0; f_valid = 0; f_vec = 0; f_mask = 0;
    for (int v = 0; v < 4; v++) begin
      if (da[v] || db[v]) begin
        e++;
        if (f_valid == 0) begin
          f_valid = 1;
          f_vec   = v;
          f_mask  = {30'd0, da[v], db[v]};
        end
      end
    end
  endfunction

  task automatic run_sweep(input string tag, input int s, input logic [3:0] fa,
                           input logic [3:0] fb, input int exp_err, input int exp_ffv,
                           input int exp_fvec, input int exp_fmask, input int restart_at);
    int st;
    int cyc;
    int iter;
    int seq_ok;
    bit pulsed;
    st = (s == 0) ? 1 : 0;
    cyc = 0; iter = 0; seq_ok = 1; pulsed = 1'b0;
    @(negedge clk);
    ta[s] = fa; tb_t[s] = fb; start_s[s] = 1'b1;
    @(negedge clk);
    start_s[s] = 1'b0;
    check({tag, "_start_busy"}, int'(busy[s]), 1);
    check({tag, "_start_clear"}, int'({done[s], err[s], ffv[s], ffvec[s], mask[s]}), 0);
    while (!done[s] && iter < 100) begin
      if (busy[s]) begin
        if (int'(xv[s]) != cyc / (st + 1)) seq_ok = 0;
        cyc++;
      end
      start_s[s] = 1'b0;
      if (!pulsed && restart_at >= 0 && int'(xv[s]) == restart_at) begin
        start_s[s] = 1'b1;
        pulsed = 1'b1;
      end
      iter++;
      @(negedge clk);
    end
    start_s[s] = 1'b0;
    check({tag, "_done"}, int'(done[s]), 1);
    check({tag, "_busy_len"}, cyc, 4 * (st + 1));
    check({tag, "_xvec_seq"}, seq_ok, 1);
    check({tag, "_busy_low"}, int'(busy[s]), 0);
    check({tag, "_pass"}, int'(pass[s]), (exp_err == 0) ? 1 : 0);
    check({tag, "_err_cnt"}, int'(err[s]), exp_err);
    check({tag, "_ff_valid"}, int'(ffv[s]), exp_ffv);
    check({tag, "_ff_vec"}, int'(ffvec[s]), exp_fvec);
    check({tag, "_ff_mask"}, int'(mask[s]), exp_fmask);
    check({tag, "_xvec_last"}, int'(xv[s]), 3);
  endtask

  initial begin
    int e, fv, fvec, fm, s;
    logic [3:0] ra, rb;

    tbl[0] = '{0, 4'b0010, 4'b0111, 0, 0, 0, 0, -1};
    tbl[1] = '{0, 4'b0010, 4'b1110, 2, 1, 0, 1, -1};
    tbl[2] = '{1, 4'b1111, 4'b0111, 3, 1, 0, 2, -1};
    tbl[3] = '{0, 4'b0010, 4'b0111, 0, 0, 0, 0, 1};
    tbl[4] = '{1, 4'b0010, 4'b0111, 0, 0, 0, 0, 2};

    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; ta[i] = ExpA; tb_t[i] = ExpB;
    end
    repeat (3) @(negedge clk);
    check_reset(0, "reset_s1");
    check_reset(1, "reset_s0");
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_sweep($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].fa, tbl[i].fb, tbl[i].err,
                tbl[i].ffv, tbl[i].fvec, tbl[i].fmask, tbl[i].restart);
    end

    // Reset during WAIT of vector 2 aborts with nothing retained.
    @(negedge clk);
    ta[0] = 4'b1111; tb_t[0] = ExpB; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pre_xvec", int'(xv[0]), 2);
    check("abort_pre_err", int'(err[0]), 1);
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    check_reset(0, "abort_reset");
    run_sweep("after_abort", 0, ExpA, ExpB, 0, 0, 0, 0, -1);

    // start and rst together: reset wins and the block stays idle.
    @(negedge clk);
    rst_s[1] = 1'b1; start_s[1] = 1'b1;
    @(negedge clk);
    rst_s[1] = 1'b0; start_s[1] = 1'b0;
    check_reset(1, "rst_start_same");
    @(negedge clk);
    check("rst_start_idle", int'(busy[1]), 0);

    for (int i = 0; i < 12; i++) begin
      s  = int'($urandom_range(1, 0));
      ra = 4'($urandom);
      rb = 4'($urandom);
      model(ra, rb, e, fv, fvec, fm);
      run_sweep($sformatf("rnd%0d", i), s, ra, rb, e, fv, fvec, fm, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential stimulus-and-response checker for two-output combinational gate modules. It is the driving/checking end of the gate-exercise interface: the gate modules receive input vectors and produce outputs, and this block generates those vectors and checks the outputs.
- Sweeps every input combination, waits a settle interval, samples both DUT outputs and compares each against a parameterized expected truth table. Reports mismatch count, first failing vector and a pass flag.
- Replaces the hand-written delay-driven stimulus blocks in the exercise benches with a reusable synthesizable checker.

Parameters:
- N_IN, 2, number of DUT inputs; vectors swept 0 .. 2**N_IN-1; vector MSB is the first DUT input (x).
- EXP_A, 4'b0010, expected truth table of DUT output A, 2**N_IN bits; bit i = expected value when vector == i. Default is ~x & y.
- EXP_B, 4'b0111, expected truth table of DUT output B, same indexing. Default is ~x | ~y.
- SETTLE, 1, wait cycles after a vector is applied before sampling, >= 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- dut_a  input  1  DUT output A.
- dut_b  input  1  DUT output B.
- x_vec  output  N_IN  vector driven to the DUT inputs.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; level, held until the next start.
- pass  output  1  valid when done; 1 iff err_cnt == 0.
- err_cnt  output  N_IN+1  number of vectors with at least one mismatching output; saturation is unnecessary.
- first_fail_valid  output  1  at least one mismatch recorded.
- first_fail_vec  output  N_IN  vector index of the first mismatch.
- first_fail_mask  output  2  {A mismatched, B mismatched} at the first failing vector.

Behaviour:
- One clock (clk), synchronous active-high reset (rst). All outputs are registered.
- Reset: state IDLE, x_vec=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0, first_fail_mask=0. rst has priority over start. rst mid-sweep aborts to IDLE with all outputs at reset values; no partial result is retained.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE or DONE with start=1:
  - go to WAIT; x_vec=0, busy=1, done=0, pass=0.
  - err_cnt, first_fail_valid, first_fail_vec and first_fail_mask clear to 0.
  - Settle counter loads SETTLE. If SETTLE==0, go straight to CHECK.
- WAIT: counter decrements each cycle. Exactly SETTLE cycles are spent in WAIT, then go to CHECK.
- CHECK (1 cycle): dut_a and dut_b are sampled at the end of this cycle.
  - ma = dut_a ^ EXP_A[x_vec]; mb = dut_b ^ EXP_B[x_vec].
  - If ma|mb: err_cnt += 1. If first_fail_valid==0, also set first_fail_valid=1, first_fail_vec=x_vec, first_fail_mask={ma,mb}. Later failures do not overwrite the first-fail record.
  - If x_vec == 2**N_IN-1: go to DONE; busy=0, done=1, pass=(final err_cnt==0).
  - Otherwise: x_vec += 1, reload the counter, go to WAIT (or CHECK if SETTLE==0).
- Timing:
  - x_vec is stable for exactly SETTLE+1 cycles per vector.
  - busy is high for exactly 2**N_IN*(SETTLE+1) cycles.
  - done rises on the cycle after the last CHECK.
- start while busy is ignored; no restart and no effect on counters.
- DONE holds all results and x_vec = last vector until start or rst.
- X/Z on dut inputs is not handled; the DUT must drive known values.

Test Plan:
- Correct DUT (A=~x&y, B=~x|~y), SETTLE=1: pulse start -> x_vec sequence 0,0,1,1,2,2,3,3; busy high 8 cycles; done=1, pass=1, err_cnt=0, first_fail_valid=0.
- DUT B replaced by x|y, SETTLE=1 -> mismatches at vectors 0 and 3; err_cnt=2, first_fail_vec=0, first_fail_mask=2'b01, pass=0.
- DUT A stuck at 1, SETTLE=0 -> busy 4 cycles; mismatches at vectors 0, 2, 3; err_cnt=3, first_fail_vec=0, first_fail_mask=2'b10.
- Assert rst during the WAIT for vector 2 -> next cycle all outputs at reset values; a new start then produces a full clean sweep with pass=1.
- start pulsed again at vector 1 mid-sweep -> ignored, sweep length unchanged. start in DONE -> results cleared and a new sweep begins on the following cycle.
- start and rst asserted in the same cycle -> stays IDLE, busy=0.
